// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin, LSB first, one borrow flop,
// operands in and result out through valid/ready handshakes.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic br, rbit, br_nx;
  assign rbit  = sa[0] ^ sb[0] ^ br;
  assign br_nx = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid && in_ready) state_nx = SHIFT;
    else if (state == SHIFT && cnt == LAST) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // diff fills from the MSB end so the first (LSB) result bit lands in bit 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      cnt       <= '0;
      br        <= 1'b0;
      sa        <= '0;
      sb        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sa       <= a;
            sb       <= b;
            br       <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          diff <= {rbit, diff[WIDTH-1:1]};
          br   <= br_nx;
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout      <= br_nx;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor computing `a - b - bin` one bit per clock, LSB first. It is the inverse-direction companion to the team's parallel ripple-carry adder. It trades area for latency, with one borrow flop instead of a borrow chain. Operands enter and the result leaves through valid/ready handshakes, so the block sits between a producer and a consumer stage of the datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: rising-edge clock, sole clock domain.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: operands on `a`, `b`, `bin` are valid.
- `in_ready` output 1: block can accept operands; registered.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `bin` input 1: borrow in.
- `out_valid` output 1: `diff` and `bout` hold a completed result.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: borrow out; 1 iff `a < b + bin` (unsigned).

## Operation
- States:
  - IDLE: `in_ready=1`.
  - SHIFT: WIDTH bit-steps.
  - DONE: `out_valid=1`.
- Reset (`rst_n` low at a clock edge):
  - state goes to IDLE.
  - `in_ready=0`, `out_valid=0`, `diff=0`, `bout=0`, bit counter 0, borrow flop 0.
  - `in_ready` rises on the first edge with `rst_n` high.
- IDLE → SHIFT on an edge with `in_valid & in_ready`:
  - latch `a` and `b` into shift registers.
  - borrow flop ← `bin`; counter ← 0; `in_ready` ← 0.
- SHIFT, each edge, with `ai`, `bi` = current LSBs of the shift registers and `br` = borrow flop:
  - result bit = `ai ^ bi ^ br`, shifted into `diff` from the MSB end.
  - `br` ← `(~ai & bi) | (~ai & br) | (bi & br)`.
  - operand registers shift right by one; counter increments.
- SHIFT → DONE on the edge where counter = WIDTH-1 (the WIDTH-th step):
  - `bout` ← final `br`; `out_valid` ← 1.
- During SHIFT, `diff` shows partial contents. Consumers qualify `diff` with `out_valid`.
- DONE:
  - `diff` and `bout` held stable while `out_valid=1`.
  - on an edge with `out_ready=1`: `out_valid` ← 0, `in_ready` ← 1, state ← IDLE.
- After handoff, `diff` and `bout` keep their values until the next operation's first SHIFT step.
- `in_valid` is ignored whenever `in_ready=0`. Operands are sampled only at the accepting edge; later changes on `a`, `b`, `bin` have no effect.
- `out_ready` is ignored outside DONE.
- Arithmetic: all values unsigned. Full wrap-around modulo `2^WIDTH`; the borrow is reported only via `bout`.

## Timing
- All outputs are registered. There are no combinational paths from any input to any output.
- Latency: accepting edge T0. SHIFT steps run on edges T1..T(WIDTH). `out_valid` is high after edge T(WIDTH), i.e. WIDTH cycles after acceptance.
- Result handoff edge Th; `in_ready` is high after Th. The earliest next accept is edge Th+1.
- Minimum issue interval: WIDTH+2 cycles with `out_ready` held high.
- A same-cycle result handoff and new accept are impossible by construction (`in_ready=0` in DONE).
- Reset mid-SHIFT or mid-DONE: the operation is abandoned and no `out_valid` pulse is produced. Outputs return to reset values on that edge.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with `in_valid=1` → `in_ready=0`, `out_valid=0`, `diff=0`, `bout=0` throughout; `in_ready=1` one cycle after release; no operation accepted during reset.
- Basic: WIDTH=8, `a=200`, `b=55`, `bin=0` → `diff=0x91` (145), `bout=0`; `out_valid` rises exactly 8 cycles after the accepting edge.
- Wrap/borrow:
  - `a=0x00`, `b=0x01`, `bin=0` → `diff=0xFF`, `bout=1`.
  - `a=0x80`, `b=0x80`, `bin=1` → `diff=0xFF`, `bout=1`.
  - `a=0xFF`, `b=0x00`, `bin=1` → `diff=0xFE`, `bout=0`.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE while toggling `in_valid` and the operands → `out_valid`, `diff`, `bout` stable; `in_ready=0`; nothing accepted. Raise `out_ready` → `out_valid=0` and `in_ready=1` next cycle.
- Reset mid-op: assert `rst_n=0` for one cycle at SHIFT step 4 → outputs return to reset values with no `out_valid`. The following operation `a=0x10`, `b=0x01` yields `diff=0x0F`, `bout=0`.
- Random: 1000 operations with random operands/`bin` and random `in_valid`/`out_ready` stalls, at WIDTH=8 and WIDTH=16 → every result matches `a - b - bin` (diff mod `2^WIDTH`, borrow flag); one result per accept; order preserved.
